// File: rtl/onchip_mem_arbiter.sv
// Two-port arbiter sharing one single-port on-chip RAM: port A writes, port B reads (Avalon-MM).
// Strict-alternation arbitration, address bounds checking with a sticky error, and a port A write counter.
module onchip_mem_arbiter #(
    parameter int AW    = 17,
    parameter int DW    = 32,
    parameter int DEPTH = 87500
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            a_valid,
    input  logic [AW-1:0]   a_address,
    input  logic [DW-1:0]   a_writedata,
    input  logic [DW/8-1:0] a_byteenable,
    output logic            a_ready,
    input  logic            b_read,
    input  logic [AW-1:0]   b_address,
    output logic            b_waitrequest,
    output logic [DW-1:0]   b_readdata,
    output logic            b_readdatavalid,
    output logic [AW-1:0]   mem_address,
    output logic [DW/8-1:0] mem_byteenable,
    output logic [DW-1:0]   mem_writedata,
    output logic            mem_chipselect,
    output logic            mem_write,
    output logic            mem_clken,
    input  logic [DW-1:0]   mem_readdata,
    input  logic            err_clr,
    output logic            err_oob,
    output logic [AW-1:0]   a_count
);
    // One extra bit so that DEPTH == 2**AW still compares correctly.
    localparam logic [AW:0] LIMIT = (AW+1)'(DEPTH);

    typedef enum logic {GRANT_A = 1'b0, GRANT_B = 1'b1} grant_e;

    grant_e        r_last_grant;
    logic          r_rd_valid;
    logic          r_rd_oob;
    logic          r_err_oob;
    logic [AW-1:0] r_a_count;

    logic w_grant_a;
    logic w_grant_b;
    logic w_a_inrange;
    logic w_b_inrange;
    logic w_oob_hit;

    assign w_a_inrange = ({1'b0, a_address} < LIMIT);
    assign w_b_inrange = ({1'b0, b_address} < LIMIT);

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        w_grant_a = 1'b0;
        w_grant_b = 1'b0;
        if (reset_n) begin
            if (a_valid && b_read) begin
                w_grant_a = (r_last_grant == GRANT_B);
                w_grant_b = (r_last_grant == GRANT_A);
            end else begin
                w_grant_a = a_valid;
                w_grant_b = b_read;
            end
        end
    end

    // Out-of-range requests still complete their handshake but never reach the RAM.
    always_comb begin
        mem_address    = '0;
        mem_writedata  = '0;
        mem_byteenable = '0;
        mem_chipselect = 1'b0;
        mem_write      = 1'b0;
        if (w_grant_a) begin
            mem_address    = a_address;
            mem_writedata  = a_writedata;
            mem_byteenable = a_byteenable;
            mem_chipselect = w_a_inrange;
            mem_write      = w_a_inrange;
        end else if (w_grant_b) begin
            mem_address    = b_address;
            mem_byteenable = '1;
            mem_chipselect = w_b_inrange;
        end
    end

    assign w_oob_hit = (w_grant_a && !w_a_inrange) || (w_grant_b && !w_b_inrange);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_last_grant <= GRANT_B;
            r_rd_valid   <= 1'b0;
            r_rd_oob     <= 1'b0;
            r_err_oob    <= 1'b0;
            r_a_count    <= '0;
        end else begin
            if (w_grant_a) begin
                r_last_grant <= GRANT_A;
            end else if (w_grant_b) begin
                r_last_grant <= GRANT_B;
            end
            r_rd_valid <= w_grant_b;
            r_rd_oob   <= w_grant_b && !w_b_inrange;
            // A new violation beats a coincident clear.
            if (w_oob_hit) begin
                r_err_oob <= 1'b1;
            end else if (err_clr) begin
                r_err_oob <= 1'b0;
            end
            if (err_clr) begin
                r_a_count <= AW'(w_grant_a);
            end else if (w_grant_a) begin
                r_a_count <= r_a_count + 1'b1;
            end
        end
    end

    assign a_ready         = w_grant_a;
    assign b_waitrequest   = ~w_grant_b;
    assign b_readdatavalid = r_rd_valid;
    assign b_readdata      = (r_rd_valid && !r_rd_oob) ? mem_readdata : '0;
    assign err_oob         = r_err_oob;
    assign a_count         = r_a_count;
    assign mem_clken       = reset_n;

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Bench for onchip_mem_arbiter: directed vector table, reset corner sequence, randomized
// traffic against a transaction-level model, and a narrow instance for counter wrap.
module tb_onchip_mem_arbiter;
    localparam int AW    = 17;
    localparam int DW    = 32;
    localparam int BW    = DW/8;
    localparam int DEPTH = 87500;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic            a_valid = 1'b0;
    logic [AW-1:0]   a_address = '0;
    logic [DW-1:0]   a_writedata = '0;
    logic [BW-1:0]   a_byteenable = '0;
    logic            a_ready;
    logic            b_read = 1'b0;
    logic [AW-1:0]   b_address = '0;
    logic            b_waitrequest;
    logic [DW-1:0]   b_readdata;
    logic            b_readdatavalid;
    logic [AW-1:0]   mem_address;
    logic [BW-1:0]   mem_byteenable;
    logic [DW-1:0]   mem_writedata;
    logic            mem_chipselect;
    logic            mem_write;
    logic            mem_clken;
    logic [DW-1:0]   mem_readdata = '0;
    logic            err_clr = 1'b0;
    logic            err_oob;
    logic [AW-1:0]   a_count;

    onchip_mem_arbiter #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) u_dut (
        .clk(clk), .reset_n(reset_n),
        .a_valid(a_valid), .a_address(a_address), .a_writedata(a_writedata),
        .a_byteenable(a_byteenable), .a_ready(a_ready),
        .b_read(b_read), .b_address(b_address), .b_waitrequest(b_waitrequest),
        .b_readdata(b_readdata), .b_readdatavalid(b_readdatavalid),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable),
        .mem_writedata(mem_writedata), .mem_chipselect(mem_chipselect),
        .mem_write(mem_write), .mem_clken(mem_clken), .mem_readdata(mem_readdata),
        .err_clr(err_clr), .err_oob(err_oob), .a_count(a_count)
    );

    // Narrow instance: makes the 2**AW counter wrap reachable in a few cycles.
    logic       s_a_valid = 1'b0;
    logic [3:0] s_a_address = '0;
    logic [7:0] s_a_writedata = '0;
    logic [0:0] s_a_byteenable = '0;
    logic       s_a_ready;
    logic       s_b_read = 1'b0;
    logic [3:0] s_b_address = '0;
    logic       s_b_waitrequest;
    logic [7:0] s_b_readdata;
    logic       s_b_readdatavalid;
    logic [3:0] s_mem_address;
    logic [0:0] s_mem_byteenable;
    logic [7:0] s_mem_writedata;
    logic       s_mem_chipselect;
    logic       s_mem_write;
    logic       s_mem_clken;
    logic [7:0] s_mem_readdata = 8'h5A;
    logic       s_err_clr = 1'b0;
    logic       s_err_oob;
    logic [3:0] s_a_count;

    onchip_mem_arbiter #(.AW(4), .DW(8), .DEPTH(12)) u_small (
        .clk(clk), .reset_n(reset_n),
        .a_valid(s_a_valid), .a_address(s_a_address), .a_writedata(s_a_writedata),
        .a_byteenable(s_a_byteenable), .a_ready(s_a_ready),
        .b_read(s_b_read), .b_address(s_b_address), .b_waitrequest(s_b_waitrequest),
        .b_readdata(s_b_readdata), .b_readdatavalid(s_b_readdatavalid),
        .mem_address(s_mem_address), .mem_byteenable(s_mem_byteenable),
        .mem_writedata(s_mem_writedata), .mem_chipselect(s_mem_chipselect),
        .mem_write(s_mem_write), .mem_clken(s_mem_clken), .mem_readdata(s_mem_readdata),
        .err_clr(s_err_clr), .err_oob(s_err_oob), .a_count(s_a_count)
    );

    // Behavioural single-port RAM with one-cycle read latency.
    logic [DW-1:0] ram [DEPTH] = '{default: '0};
    always @(posedge clk) begin
        if (mem_clken && mem_chipselect) begin
            if (mem_write) begin
                for (int k = 0; k < BW; k++) begin
                    if (mem_byteenable[k]) ram[int'(mem_address)][8*k +: 8] <= mem_writedata[8*k +: 8];
                end
            end else begin
                mem_readdata <= ram[int'(mem_address)];
            end
        end
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic          av;
        logic [AW-1:0] aa;
        logic [DW-1:0] ad;
        logic [BW-1:0] abe;
        logic          br;
        logic [AW-1:0] ba;
        logic          clr;
        logic          e_ardy;
        logic          e_bwait;
        logic          e_cs;
        logic          e_we;
        logic [AW-1:0] e_addr;
        logic          e_rv;
        logic [DW-1:0] e_rd;
        logic          e_err;
        logic [AW-1:0] e_cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                                input logic [BW-1:0] abe, input logic br, input logic [AW-1:0] ba,
                                input logic clr, input logic ardy, input logic bw, input logic cs,
                                input logic we, input logic [AW-1:0] addr, input logic rv,
                                input logic [DW-1:0] rd, input logic er, input logic [AW-1:0] cnt);
        vec_t v;
        v.av = av; v.aa = aa; v.ad = ad; v.abe = abe; v.br = br; v.ba = ba; v.clr = clr;
        v.e_ardy = ardy; v.e_bwait = bw; v.e_cs = cs; v.e_we = we; v.e_addr = addr;
        v.e_rv = rv; v.e_rd = rd; v.e_err = er; v.e_cnt = cnt;
        tbl.push_back(v);
    endfunction

    // Transaction-level model state for the random phase.
    int            hist[$];   // order of grants: 0 = A, 1 = B
    logic [DW-1:0] rd_q[$];   // read responses due on the next cycle
    logic [DW-1:0] mdl_mem [int];
    int            m_writes;
    bit            m_err;

    function automatic logic [DW-1:0] mdl_read(input int addr);
        return mdl_mem.exists(addr) ? mdl_mem[addr] : '0;
    endfunction

    function automatic logic [AW-1:0] pick_addr();
        int r;
        r = int'($urandom_range(0, 9));
        if (r <= 5) return AW'(2000 + int'($urandom_range(0, 7)));
        if (r == 6) return AW'(87490 + int'($urandom_range(0, 7)));
        if (r <= 8) return AW'(DEPTH + int'($urandom_range(0, 3)));
        return '1;
    endfunction

    vec_t          v;
    logic          want_a, want_b, a_inr, b_inr, exp_cs, exp_rv;
    logic [DW-1:0] exp_rd, merged;

    initial begin
        // Columns: a_valid a_addr a_data a_be b_read b_addr err_clr |
        //          a_ready b_wait cs we addr rdvalid rddata err count
        add(1, 0, 'h11, 'hF, 0, 0, 0,   1, 1, 1, 1, 0,   0, 0, 0, 0);
        add(1, 1, 'h22, 'hF, 0, 0, 0,   1, 1, 1, 1, 1,   0, 0, 0, 1);
        add(1, 2, 'h33, 'hF, 0, 0, 0,   1, 1, 1, 1, 2,   0, 0, 0, 2);
        add(1, 3, 'h44, 'hF, 0, 0, 0,   1, 1, 1, 1, 3,   0, 0, 0, 3);
        add(0, 0, 0, 0,      1, 0, 0,   0, 0, 1, 0, 0,   0, 0, 0, 4);
        add(0, 0, 0, 0,      1, 1, 0,   0, 0, 1, 0, 1,   1, 'h11, 0, 4);
        add(0, 0, 0, 0,      1, 2, 0,   0, 0, 1, 0, 2,   1, 'h22, 0, 4);
        add(0, 0, 0, 0,      0, 0, 0,   0, 1, 0, 0, 0,   1, 'h33, 0, 4);
        // Contention held for six cycles: strict alternation starting with A.
        add(1, 4, 'h55, 'hF, 1, 3, 0,   1, 1, 1, 1, 4,   0, 0, 0, 4);
        add(1, 4, 'h55, 'hF, 1, 3, 0,   0, 0, 1, 0, 3,   0, 0, 0, 5);
        add(1, 4, 'h55, 'hF, 1, 3, 0,   1, 1, 1, 1, 4,   1, 'h44, 0, 5);
        add(1, 4, 'h55, 'hF, 1, 3, 0,   0, 0, 1, 0, 3,   0, 0, 0, 6);
        add(1, 4, 'h55, 'hF, 1, 3, 0,   1, 1, 1, 1, 4,   1, 'h44, 0, 6);
        add(1, 4, 'h55, 'hF, 1, 3, 0,   0, 0, 1, 0, 3,   0, 0, 0, 7);
        add(0, 0, 0, 0,      0, 0, 0,   0, 1, 0, 0, 0,   1, 'h44, 0, 7);
        // Out-of-range read, then error clear.
        add(0, 0, 0, 0,      1, 87500, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7);
        add(0, 0, 0, 0,      0, 0, 0,   0, 1, 0, 0, 0,   1, 0, 1, 7);
        add(0, 0, 0, 0,      0, 0, 1,   0, 1, 0, 0, 0,   0, 0, 1, 7);
        add(0, 0, 0, 0,      0, 0, 0,   0, 1, 0, 0, 0,   0, 0, 0, 0);
        // Out-of-range write, clear with in-range write, clear coincident with a new violation.
        add(1, 90000, 'hDEAD, 'hF, 0, 0, 0,  1, 1, 0, 0, 0,     0, 0, 0, 0);
        add(1, 87499, 'h66, 'hF,   0, 0, 1,  1, 1, 1, 1, 87499, 0, 0, 1, 1);
        add(1, 100000, 'h77, 'hF,  0, 0, 1,  1, 1, 0, 0, 0,     0, 0, 0, 1);
        add(0, 0, 0, 0,      1, 87499, 0,    0, 0, 1, 0, 87499, 0, 0, 1, 1);
        add(0, 0, 0, 0,      0, 0, 0,        0, 1, 0, 0, 0,     1, 'h66, 1, 1);
        // Partial byte-enable write and read-back.
        add(1, 1, 'hAABBCCDD, 'h5, 0, 0, 0,  1, 1, 1, 1, 1,     0, 0, 1, 1);
        add(0, 0, 0, 0,      1, 1, 0,        0, 0, 1, 0, 1,     0, 0, 1, 2);
        add(0, 0, 0, 0,      0, 0, 0,        0, 1, 0, 0, 0,     1, 'h00BB00DD, 1, 2);

        // Reset state with both ports requesting.
        reset_n = 1'b0;
        a_valid = 1'b1; b_read = 1'b1; a_address = 'd7; b_address = 'd7;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst a_ready", a_ready, 0);
        check("rst b_waitrequest", b_waitrequest, 1);
        check("rst mem_chipselect", mem_chipselect, 0);
        check("rst mem_write", mem_write, 0);
        check("rst mem_clken", mem_clken, 0);
        check("rst b_readdatavalid", b_readdatavalid, 0);
        check("rst b_readdata", b_readdata, 0);
        check("rst err_oob", err_oob, 0);
        check("rst a_count", a_count, 0);
        @(posedge clk); #1;
        reset_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            v = tbl[i];
            a_valid = v.av; a_address = v.aa; a_writedata = v.ad; a_byteenable = v.abe;
            b_read = v.br; b_address = v.ba; err_clr = v.clr;
            @(negedge clk);
            check($sformatf("row%0d a_ready", i), a_ready, v.e_ardy);
            check($sformatf("row%0d b_waitrequest", i), b_waitrequest, v.e_bwait);
            check($sformatf("row%0d mem_chipselect", i), mem_chipselect, v.e_cs);
            check($sformatf("row%0d mem_write", i), mem_write, v.e_we);
            check($sformatf("row%0d mem_clken", i), mem_clken, 1);
            if (v.e_cs) check($sformatf("row%0d mem_address", i), mem_address, v.e_addr);
            if (v.e_we) begin
                check($sformatf("row%0d mem_writedata", i), mem_writedata, v.ad);
                check($sformatf("row%0d mem_byteenable", i), mem_byteenable, v.abe);
            end
            if (v.e_cs && !v.e_we) check($sformatf("row%0d read byteenable", i), mem_byteenable, 'hF);
            check($sformatf("row%0d b_readdatavalid", i), b_readdatavalid, v.e_rv);
            if (v.e_rv) check($sformatf("row%0d b_readdata", i), b_readdata, v.e_rd);
            check($sformatf("row%0d err_oob", i), err_oob, v.e_err);
            check($sformatf("row%0d a_count", i), a_count, v.e_cnt);
            @(posedge clk); #1;
        end

        // Reset asserted in the cycle after a B grant: the pending read must vanish.
        a_valid = 1'b0; b_read = 1'b1; b_address = 'd2; err_clr = 1'b0;
        @(negedge clk);
        check("pre-rst read granted", b_waitrequest, 0);
        @(posedge clk); #1;
        reset_n = 1'b0;
        a_valid = 1'b1; a_address = 'd5; a_writedata = 'h99; a_byteenable = 'hF;
        @(negedge clk);
        check("midrst b_readdatavalid", b_readdatavalid, 0);
        check("midrst b_readdata", b_readdata, 0);
        check("midrst a_ready", a_ready, 0);
        check("midrst b_waitrequest", b_waitrequest, 1);
        check("midrst mem_chipselect", mem_chipselect, 0);
        check("midrst mem_write", mem_write, 0);
        check("midrst mem_clken", mem_clken, 0);
        check("midrst err_oob", err_oob, 0);
        check("midrst a_count", a_count, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("midrst2 b_readdatavalid", b_readdatavalid, 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        check("post-rst contention a_ready", a_ready, 1);
        check("post-rst contention b_waitrequest", b_waitrequest, 1);
        check("post-rst b_readdatavalid", b_readdatavalid, 0);
        check("post-rst mem_address", mem_address, 5);
        @(posedge clk); #1;
        a_valid = 1'b0; b_read = 1'b0;
        @(negedge clk);
        check("post-rst2 b_readdatavalid", b_readdatavalid, 0);
        check("post-rst2 a_count", a_count, 1);
        check("post-rst2 err_oob", err_oob, 0);

        // Fresh reset, then randomized traffic against the model.
        @(posedge clk); #1;
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        hist.delete(); rd_q.delete(); m_writes = 0; m_err = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            a_valid = ($urandom_range(0, 99) < 60);
            b_read = ($urandom_range(0, 99) < 60);
            a_address = pick_addr();
            b_address = pick_addr();
            a_writedata = $urandom;
            a_byteenable = BW'($urandom_range(0, 15));
            err_clr = ($urandom_range(0, 99) < 5);
            @(negedge clk);
            want_a = a_valid && (!b_read || hist.size() == 0 || hist[$] == 1);
            want_b = b_read && !want_a;
            a_inr = (int'(a_address) < DEPTH);
            b_inr = (int'(b_address) < DEPTH);
            exp_cs = (want_a && a_inr) || (want_b && b_inr);
            check("rnd a_ready", a_ready, want_a);
            check("rnd b_waitrequest", b_waitrequest, !want_b);
            check("rnd mem_chipselect", mem_chipselect, exp_cs);
            check("rnd mem_write", mem_write, want_a && a_inr);
            if (exp_cs) check("rnd mem_address", mem_address, want_a ? a_address : b_address);
            if (want_a && a_inr) begin
                check("rnd mem_writedata", mem_writedata, a_writedata);
                check("rnd mem_byteenable", mem_byteenable, a_byteenable);
            end
            exp_rv = (rd_q.size() > 0);
            check("rnd b_readdatavalid", b_readdatavalid, exp_rv);
            if (exp_rv) begin
                exp_rd = rd_q.pop_front();
                check("rnd b_readdata", b_readdata, exp_rd);
            end
            check("rnd err_oob", err_oob, m_err);
            check("rnd a_count", a_count, 64'(m_writes % (1 << AW)));
            if (want_a) begin
                hist.push_back(0);
                m_writes++;
                if (a_inr) begin
                    merged = mdl_read(int'(a_address));
                    for (int k = 0; k < BW; k++) begin
                        if (a_byteenable[k]) merged[8*k +: 8] = a_writedata[8*k +: 8];
                    end
                    mdl_mem[int'(a_address)] = merged;
                end
            end
            if (want_b) begin
                hist.push_back(1);
                rd_q.push_back(b_inr ? mdl_read(int'(b_address)) : '0);
            end
            if ((want_a && !a_inr) || (want_b && !b_inr)) m_err = 1'b1;
            else if (err_clr) m_err = 1'b0;
            if (err_clr) m_writes = want_a ? 1 : 0;
            if (hist.size() > 4) void'(hist.pop_front());
            @(posedge clk); #1;
        end
        a_valid = 1'b0; b_read = 1'b0; err_clr = 1'b0;

        // Narrow instance: counter wrap modulo 16 and bound at DEPTH = 12.
        s_a_address = 4'd11; s_a_writedata = 8'hC3; s_a_byteenable = 1'b1;
        for (int k = 0; k < 18; k++) begin
            s_a_valid = (k < 17);
            @(negedge clk);
            check($sformatf("small a_count k%0d", k), s_a_count, 64'(k % 16));
            if (k == 0) check("small in-range chipselect", s_mem_chipselect, 1);
            @(posedge clk); #1;
        end
        s_a_valid = 1'b1; s_a_address = 4'd12;
        @(negedge clk);
        check("small oob a_ready", s_a_ready, 1);
        check("small oob chipselect", s_mem_chipselect, 0);
        check("small err before", s_err_oob, 0);
        @(posedge clk); #1;
        s_a_valid = 1'b0; s_b_read = 1'b1; s_b_address = 4'd12;
        @(negedge clk);
        check("small err set", s_err_oob, 1);
        check("small a_count oob", s_a_count, 2);
        check("small oob read accepted", s_b_waitrequest, 0);
        check("small oob read chipselect", s_mem_chipselect, 0);
        @(posedge clk); #1;
        s_b_address = 4'd11;
        @(negedge clk);
        check("small oob rdvalid", s_b_readdatavalid, 1);
        check("small oob rddata", s_b_readdata, 0);
        check("small inr read chipselect", s_mem_chipselect, 1);
        @(posedge clk); #1;
        s_b_read = 1'b0; s_err_clr = 1'b1;
        @(negedge clk);
        check("small inr rdvalid", s_b_readdatavalid, 1);
        check("small inr rddata", s_b_readdata, 'h5A);
        check("small err held during clr", s_err_oob, 1);
        @(posedge clk); #1;
        s_err_clr = 1'b0;
        @(negedge clk);
        check("small err cleared", s_err_oob, 0);
        check("small a_count cleared", s_a_count, 0);
        check("small rdvalid idle", s_b_readdatavalid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
